fifo_u_word_ctrl: RTL and testbench

- Word-level sequencer and arbiter placed in front of the 1-bit serial FIFO (fifo_stack_u) in the USB3300 sniffer.
- Accepts DATA_W-bit write words and read requests, and arbitrates between them.
- Serialises each word into per-bit save/pop strobes that honour the FIFO busy handshake.
- Tracks FIFO occupancy in bits, so it never starts a word that cannot complete.

---
 rtl/fifo_u_word_ctrl_if.sv | 29 ++
 rtl/fifo_u_word_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fifo_u_word_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_u_word_ctrl_if.sv
// Word-side handshake between a client and the serial FIFO word controller.
interface fifo_u_word_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] I_WORD;
  logic              wr_req;
  logic              wr_ack;
  logic              rd_req;
  logic              rd_ack;
  logic [DATA_W-1:0] O_WORD;
  logic              rd_valid;
  logic              flush;
  logic [LVL_W-1:0]  level;
  logic              ctrl_busy;
  logic              err;

  modport master (
    output I_WORD, wr_req, rd_req, flush,
    input  wr_ack, rd_ack, O_WORD, rd_valid, level, ctrl_busy, err
  );

  modport slave (
    input  I_WORD, wr_req, rd_req, flush,
    output wr_ack, rd_ack, O_WORD, rd_valid, level, ctrl_busy, err
  );
endinterface

// File: rtl/fifo_u_word_ctrl.sv
// Word sequencer/arbiter in front of the 1-bit serial FIFO: serialises words into
// per-bit save/pop strobes under the FIFO busy handshake and tracks occupancy in bits.
module fifo_u_word_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  fifo_u_word_ctrl_if.slave  w,
  output logic               F_DATA,
  output logic               F_save,
  output logic               F_pop,
  output logic               F_reset,
  input  logic               F_O_DATA,
  input  logic               F_full,
  input  logic               F_empty,
  input  logic               F_busy
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] WR_MAX   = LVL_W'(DEPTH - DATA_W);
  localparam logic [LVL_W-1:0] RD_MIN   = LVL_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, W_STB, W_WAIT, R_STB, R_WAIT, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   bit_idx;
  logic [LVL_W-1:0]   level_q;
  logic [DATA_W-1:0]  wr_word;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  rd_word_nxt;
  logic [DATA_W-1:0]  o_word_q;
  logic               rd_valid_q;
  logic               prio_wr;
  logic               wr_ack_c, rd_ack_c, err_c;
  logic               wr_elig, rd_elig, last_bit;
  logic [IDX_W-1:0]   pos;

  function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] v);
    return (v >= LVL_MAX) ? LVL_MAX : v + LVL_W'(1);
  endfunction

  function automatic logic [LVL_W-1:0] sat_dec(input logic [LVL_W-1:0] v);
    return (v == '0) ? '0 : v - LVL_W'(1);
  endfunction

  assign wr_elig  = w.wr_req && (level_q <= WR_MAX);
  assign rd_elig  = w.rd_req && (level_q >= RD_MIN);
  assign last_bit = (bit_idx == LAST_IDX);
  assign pos      = LSB_FIRST ? bit_idx : (LAST_IDX - bit_idx);

  always_comb begin
    rd_word_nxt      = shreg;
    rd_word_nxt[pos] = F_O_DATA;
  end

  always_comb begin
    state_d  = state_q;
    wr_ack_c = 1'b0;
    rd_ack_c = 1'b0;
    err_c    = 1'b0;
    F_save   = 1'b0;
    F_pop    = 1'b0;
    F_reset  = 1'b0;
    F_DATA   = 1'b0;
    case (state_q)
      IDLE: begin
        // No accept in the rd_valid cycle keeps the three pulses mutually exclusive.
        if (!reset && !rd_valid_q) begin
          if (w.flush) begin
            state_d = FLUSH;
          end else if (wr_elig && (!rd_elig || prio_wr)) begin
            wr_ack_c = 1'b1;
            state_d  = W_STB;
          end else if (rd_elig) begin
            rd_ack_c = 1'b1;
            state_d  = R_STB;
          end
        end
      end
      W_STB: begin
        if (F_full) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else if (!F_busy) begin
          F_save  = 1'b1;
          F_DATA  = wr_word[pos];
          state_d = W_WAIT;
        end
      end
      W_WAIT: if (!F_busy) state_d = last_bit ? IDLE : W_STB;
      R_STB: begin
        if (F_empty) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else if (!F_busy) begin
          F_pop   = 1'b1;
          state_d = R_WAIT;
        end
      end
      R_WAIT: if (!F_busy) state_d = last_bit ? IDLE : R_STB;
      FLUSH: begin
        F_reset = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_idx    <= '0;
      level_q    <= '0;
      o_word_q   <= '0;
      rd_valid_q <= 1'b0;
      prio_wr    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= 1'b0;
      // prio points at the side that was not served last
      if (wr_ack_c) begin
        bit_idx <= '0;
        prio_wr <= 1'b0;
      end
      if (rd_ack_c) begin
        bit_idx <= '0;
        prio_wr <= 1'b1;
      end
      if (state_q == W_WAIT && !F_busy) begin
        level_q <= sat_inc(level_q);
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (state_q == R_WAIT && !F_busy) begin
        level_q <= sat_dec(level_q);
        bit_idx <= bit_idx + IDX_W'(1);
        if (last_bit) begin
          o_word_q   <= rd_word_nxt;
          rd_valid_q <= 1'b1;
        end
      end
      if (state_q == FLUSH) level_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ack_c) wr_word <= w.I_WORD;
    if (rd_ack_c) shreg <= '0;
    else if (state_q == R_WAIT && !F_busy) shreg <= rd_word_nxt;
  end

  assign w.wr_ack    = wr_ack_c;
  assign w.rd_ack    = rd_ack_c;
  assign w.err       = err_c;
  assign w.O_WORD    = o_word_q;
  assign w.rd_valid  = rd_valid_q;
  assign w.level     = level_q;
  assign w.ctrl_busy = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_u_word_ctrl.sv
// Bench for fifo_u_word_ctrl: a bit-queue FIFO emulator plus a word scoreboard,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_fifo_u_word_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_u_word_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) wif();
  logic F_DATA, F_save, F_pop, F_reset, F_O_DATA, F_full, F_empty, F_busy;

  fifo_u_word_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .w(wif),
    .F_DATA(F_DATA), .F_save(F_save), .F_pop(F_pop), .F_reset(F_reset),
    .F_O_DATA(F_O_DATA), .F_full(F_full), .F_empty(F_empty), .F_busy(F_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Serial FIFO emulator: bit queue, optional busy window after each strobe.
  bit   fq[$];
  int   fcount = 0;
  int   busy_cnt = 0;
  int   busy_len = 0;
  logic force_full = 1'b0;
  logic f_o_data_r = 1'b0;

  assign F_O_DATA = f_o_data_r;
  assign F_busy   = (busy_cnt > 0);
  assign F_full   = force_full || (fcount >= DEPTH);
  assign F_empty  = (fcount == 0);

  always @(posedge clk) begin : fifo_emu
    logic sv, pp, rs, d;
    sv = F_save; pp = F_pop; rs = F_reset; d = F_DATA;
    #1;
    if (rs) fq.delete();
    else begin
      if (sv) fq.push_back(d);
      if (pp && fq.size() > 0) f_o_data_r = fq.pop_front();
    end
    if (sv || pp) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    fcount = fq.size();
  end

  int   cyc = 0;
  always @(posedge clk) cyc++;

  bit                save_bits[$];
  int                save_cycs[$];
  logic [DATA_W-1:0] sb[$];
  bit                acc_log[$];
  int                err_cnt = 0;
  int                freset_cnt = 0;

  // Per-cycle compare against the word scoreboard and the emulator's bit count.
  always @(negedge clk) begin
    if (!reset) begin
      if (F_save) begin
        save_bits.push_back(F_DATA);
        save_cycs.push_back(cyc);
      end
      if (F_save || F_pop) chk("no_strobe_while_busy", F_busy, 0);
      if (wif.err) err_cnt++;
      if (F_reset) freset_cnt++;
      if (wif.wr_ack || wif.rd_ack || wif.rd_valid)
        chk("one_event_per_cycle", int'(wif.wr_ack) + int'(wif.rd_ack) + int'(wif.rd_valid), 1);
      if (wif.wr_ack) begin
        sb.push_back(wif.I_WORD);
        acc_log.push_back(1'b1);
      end
      if (wif.rd_ack) acc_log.push_back(1'b0);
      if (wif.rd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_word actual=0x%0h required=no_rd_valid", wif.O_WORD);
        end else chk("rd_word", wif.O_WORD, sb.pop_front());
      end
      if (!wif.ctrl_busy) chk("level_vs_fifo_bits", wif.level, fcount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!wif.ctrl_busy) begin ok = 1; break; end
      tick();
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic start_write(input logic [DATA_W-1:0] wd);
    bit ok = 0;
    wif.I_WORD = wd;
    wif.wr_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (wif.wr_ack) begin ok = 1; break; end
      tick();
    end
    chk("wr_ack_timeout", ok, 1);
    tick();
    wif.wr_req = 1'b0;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] wd);
    start_write(wd);
    wait_idle();
  endtask

  task automatic read_word(output logic [DATA_W-1:0] got, output int lat);
    bit ok = 0;
    got = '0;
    lat = 0;
    wif.rd_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (wif.rd_ack) begin ok = 1; break; end
      tick();
    end
    chk("rd_ack_timeout", ok, 1);
    tick();
    wif.rd_req = 1'b0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (wif.rd_valid) begin ok = 1; got = wif.O_WORD; lat = i + 1; break; end
      tick();
    end
    chk("rd_valid_timeout", ok, 1);
    tick();
  endtask

  function automatic logic [DATA_W-1:0] saved_word();
    logic [DATA_W-1:0] v = '0;
    for (int k = 0; k < save_bits.size() && k < DATA_W; k++) v[k] = save_bits[k];
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [DATA_W-1:0] got;
    logic [3:0]        pat;
    int                lat;
    bit                bad;

    wif.I_WORD = '0; wif.wr_req = 1'b0; wif.rd_req = 1'b0; wif.flush = 1'b0;
    tick(); tick();
    chk("reset_word_outs", {wif.O_WORD, wif.level, wif.wr_ack, wif.rd_ack, wif.rd_valid,
                            wif.ctrl_busy, wif.err}, 0);
    chk("reset_fifo_outs", {F_DATA, F_save, F_pop, F_reset}, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_level", wif.level, 0);

    // Write 0xA5 then read it back, LSB first.
    save_bits.delete();
    write_word(8'hA5);
    chk("a5_save_count", save_bits.size(), 8);
    chk("a5_bit_order", saved_word(), 8'hA5);
    chk("a5_level", wif.level, 8);
    read_word(got, lat);
    chk("a5_read", got, 8'hA5);
    chk("a5_rd_latency_min", lat >= 2 * DATA_W, 1);
    chk("a5_level_after_read", wif.level, 0);

    // Read at level 0 stays pending until a word arrives.
    wif.rd_req = 1'b1;
    bad = 0;
    repeat (10) begin
      #1;
      if (wif.rd_ack || wif.ctrl_busy) bad = 1;
      tick();
    end
    chk("no_read_when_empty", bad, 0);
    write_word(8'h3C);
    read_word(got, lat);
    chk("pending_read_3c", got, 8'h3C);

    // Full FIFO blocks a third write until a read drains a word.
    write_word(8'h11);
    write_word(8'h22);
    chk("full_level", wif.level, 16);
    wif.I_WORD = 8'h33;
    wif.wr_req = 1'b1;
    bad = 0;
    repeat (10) begin
      #1;
      if (wif.wr_ack) bad = 1;
      tick();
    end
    chk("no_wr_ack_when_full", bad, 0);
    read_word(got, lat);
    chk("full_read_11", got, 8'h11);
    write_word(8'h33);
    read_word(got, lat);
    chk("full_read_22", got, 8'h22);
    read_word(got, lat);
    chk("full_read_33", got, 8'h33);

    // Arbitration with both requests held at level 8 after a read.
    write_word(8'h5A);
    write_word(8'h6B);
    read_word(got, lat);
    chk("arb_setup_5a", got, 8'h5A);
    chk("arb_setup_level", wif.level, 8);
    acc_log.delete();
    wif.I_WORD = 8'h7C;
    wif.wr_req = 1'b1;
    wif.rd_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (acc_log.size() >= 4) break;
    end
    wif.wr_req = 1'b0;
    wif.rd_req = 1'b0;
    wait_idle();
    pat = '0;
    for (int k = 0; k < 4 && k < acc_log.size(); k++) pat[3-k] = acc_log[k];
    chk("arb_order_wrwr", pat, 4'b1010);
    chk("arb_accept_count", acc_log.size(), 4);
    tick();
    read_word(got, lat);
    chk("arb_drain_7c", got, 8'h7C);

    // Busy high for the four wait cycles after each strobe: 6 cycles per bit.
    busy_len = 4;
    save_cycs.delete();
    write_word(8'h96);
    chk("busy_save_count", save_cycs.size(), 8);
    for (int k = 0; k + 1 < save_cycs.size(); k++)
      chk("busy_bit_spacing", save_cycs[k+1] - save_cycs[k], 6);
    read_word(got, lat);
    chk("busy_read_96", got, 8'h96);
    busy_len = 0;
    wait_idle();

    // FIFO reports full before bit 3: error abort, then flush.
    save_bits.delete();
    err_cnt = 0;
    start_write(8'hE7);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (save_bits.size() >= 3) break;
    end
    force_full = 1'b1;
    wait_idle();
    tick();
    chk("err_pulse_count", err_cnt, 1);
    chk("err_level", wif.level, 3);
    chk("err_save_count", save_bits.size(), 3);
    sb.delete();
    force_full = 1'b0;
    freset_cnt = 0;
    wif.flush = 1'b1;
    tick();
    wif.flush = 1'b0;
    tick(); tick();
    chk("flush_reset_pulses", freset_cnt, 1);
    chk("flush_level", wif.level, 0);

    // Reset mid-word, then a clean write of 0xFF.
    save_bits.delete();
    start_write(8'h81);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (save_bits.size() >= 3) break;
    end
    reset = 1'b1;
    #1;
    chk("midword_reset_word_outs", {wif.O_WORD, wif.level, wif.wr_ack, wif.rd_ack,
                                    wif.rd_valid, wif.ctrl_busy, wif.err}, 0);
    chk("midword_reset_fifo_outs", {F_DATA, F_save, F_pop, F_reset}, 0);
    fq.delete();
    fcount = 0;
    busy_cnt = 0;
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    save_bits.delete();
    write_word(8'hFF);
    chk("ff_bits", saved_word(), 8'hFF);
    chk("ff_level", wif.level, 8);
    read_word(got, lat);
    chk("ff_read", got, 8'hFF);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
